serial_adder_ctrl: RTL

Sequenced bit-serial add/subtract unit with a start/done handshake, replacing free-running load/shift control.
- Captures two WIDTH-bit operands on a start pulse.
- Shifts them LSB-first through a 1-bit full-adder slice with a carry flop, and assembles the result in a shift register.
- Presents the registered result, carry and signed overflow for one done cycle.
- Sits between a requesting master (testbench or higher-level sequencer) and the serial datapath.

---
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
`timescale 1ns/1ps
// Request/result bundle between a requesting master and the serial add/sub unit.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op_sub, in1, in2,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  start, op_sub, in1, in2,
    output busy, done, out, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bit-serial add/subtract unit: operands captured on start, processed LSB-first
// through one full-adder slice, result/carry/overflow presented with a done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  // One full-adder slice on the current LSBs.
  logic sum_bit;
  logic carry_out;
  assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_out = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.out  = out_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

  // Next-state and datapath update; subtraction is a + ~b + 1 with the +1 as carry-in.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          a_next     = bus.in1;
          b_next     = bus.op_sub ? ~bus.in2 : bus.in2;
          carry_next = bus.op_sub;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        a_next     = a_reg >> 1;
        b_next     = b_reg >> 1;
        res_next   = {sum_bit, res_reg[WIDTH-1:1]};
        carry_next = carry_out;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST_BIT) begin
          // MSB slice: carry_reg is the carry into the sign bit.
          out_next   = {sum_bit, res_reg[WIDTH-1:1]};
          cout_next  = carry_out;
          ovf_next   = carry_reg ^ carry_out;
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule
